stall_ctrl: RTL and testbench

- Hazard/stall controller for the 5-stage MIPS pipeline. Drives Stall to the D pipeline register and PC, and FlushE to the E pipeline register.
- Keeps its own shadow copy of destination-register and Tnew info for the E and M stages. This shadow advances in lockstep with the pipeline registers, bubbles included.
- Tracks the busy window of a multi-cycle mult/div unit, so that D-stage HI/LO instructions stall until it completes.

---
 rtl/stall_ctrl_pkg.sv | 28 ++
 rtl/stall_ctrl_if.sv | 25 ++
 rtl/stall_ctrl_md_busy_cnt.sv | 39 +++
 rtl/stall_ctrl.sv | 81 ++++++++
 tb/tb_stall_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/stall_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline hazard/stall controller.
// Tuse/Tnew share one 2-bit encoding space so a plain compare decides a hazard.
package stall_ctrl_pkg;

  localparam logic [1:0] TUSE_BRANCH = 2'd0;
  localparam logic [1:0] TUSE_ALU    = 2'd1;
  localparam logic [1:0] TUSE_STORE  = 2'd2;
  localparam logic [1:0] TUSE_NONE   = 2'd3;

  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A source stalls when an in-flight producer of the same register will not have
  // its result ready by the time the consumer needs it.
  function automatic logic reg_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] a3_e, input logic [1:0] tnew_e,
                                      input logic [4:0] a3_m, input logic [1:0] tnew_m);
    return (src != REG_ZERO) &&
           (((a3_e == src) && (tuse < tnew_e)) || ((a3_m == src) && (tuse < tnew_m)));
  endfunction

endpackage

// File: rtl/stall_ctrl_if.sv
// D-stage hazard information from the pipeline and stall controls back to it.
interface stall_ctrl_if;
  logic [4:0] RS_D;
  logic [4:0] RT_D;
  logic [1:0] TuseRS_D;
  logic [1:0] TuseRT_D;
  logic [4:0] A3_D;
  logic [1:0] TnewE_D;
  logic       MDStart_D;
  logic       MDIsDiv_D;
  logic       MDUse_D;
  logic       Stall;
  logic       FlushE;
  logic       Busy;

  modport master (
    output RS_D, RT_D, TuseRS_D, TuseRT_D, A3_D, TnewE_D, MDStart_D, MDIsDiv_D, MDUse_D,
    input  Stall, FlushE, Busy
  );

  modport slave (
    input  RS_D, RT_D, TuseRS_D, TuseRT_D, A3_D, TnewE_D, MDStart_D, MDIsDiv_D, MDUse_D,
    output Stall, FlushE, Busy
  );
endinterface

// File: rtl/stall_ctrl_md_busy_cnt.sv
// Busy-window counter for the multi-cycle mult/div unit.
// Busy covers the E cycle of the mult/div plus the loaded count.
module stall_ctrl_md_busy_cnt
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start,
  input  logic md_is_div,
  output logic busy
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (md_start) begin
      cnt_d = md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = md_start || (cnt_q != '0);

endmodule

// File: rtl/stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: shadows E/M destination and Tnew,
// stalls D on unresolved data hazards and on HI/LO use while mult/div is busy.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = 4
) (
  input logic        CLK,
  input logic        Reset,
  stall_ctrl_if.slave hz
);

  logic [4:0] a3_e_q, a3_e_d;
  logic [1:0] tnew_e_q, tnew_e_d;
  logic       md_start_e_q, md_start_e_d;
  logic       md_is_div_e_q, md_is_div_e_d;
  logic [4:0] a3_m_q, a3_m_d;
  logic [1:0] tnew_m_q, tnew_m_d;

  logic haz_rs, haz_rt, haz_md, busy, stall;

  stall_ctrl_md_busy_cnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_cnt (
    .clk       (CLK),
    .rst       (Reset),
    .md_start  (md_start_e_q),
    .md_is_div (md_is_div_e_q),
    .busy      (busy)
  );

  always_comb begin
    haz_rs = reg_hazard(hz.RS_D, hz.TuseRS_D, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q);
    haz_rt = reg_hazard(hz.RT_D, hz.TuseRT_D, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q);
    haz_md = hz.MDUse_D && busy;
    stall  = haz_rs || haz_rt || haz_md;
  end

  assign hz.Stall  = stall;
  assign hz.FlushE = stall;
  assign hz.Busy   = busy;

  // A stall bubbles E; MDIsDivE is only meaningful alongside MDStartE so it is left alone.
  always_comb begin
    a3_e_d        = hz.A3_D;
    tnew_e_d      = hz.TnewE_D;
    md_start_e_d  = hz.MDStart_D;
    md_is_div_e_d = hz.MDIsDiv_D;
    if (stall) begin
      a3_e_d        = REG_ZERO;
      tnew_e_d      = TNEW_LINK;
      md_start_e_d  = 1'b0;
      md_is_div_e_d = md_is_div_e_q;
    end
    a3_m_d   = a3_e_q;
    tnew_m_d = (tnew_e_q == TNEW_LINK) ? TNEW_LINK : tnew_e_q - 2'd1;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      a3_e_q        <= '0;
      tnew_e_q      <= '0;
      md_start_e_q  <= 1'b0;
      md_is_div_e_q <= 1'b0;
      a3_m_q        <= '0;
      tnew_m_q      <= '0;
    end else begin
      a3_e_q        <= a3_e_d;
      tnew_e_q      <= tnew_e_d;
      md_start_e_q  <= md_start_e_d;
      md_is_div_e_q <= md_is_div_e_d;
      a3_m_q        <= a3_m_d;
      tnew_m_q      <= tnew_m_d;
    end
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// Bench for stall_ctrl: directed table, busy-window and async-reset sequences, and random
// traffic, all checked against a ready-time model of in-flight producers.
module tb_stall_ctrl;
  import stall_ctrl_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic CLK;
  logic Reset;

  stall_ctrl_if hz_if ();

  stall_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N),
    .CNT_W       (4)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .hz    (hz_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0] rs;
    logic [1:0] tuse_rs;
    logic [4:0] rt;
    logic [1:0] tuse_rt;
    logic [4:0] a3;
    logic [1:0] tnew;
    logic       md_start;
    logic       md_div;
    logic       md_use;
  } instr_t;

  typedef struct {
    instr_t a;
    instr_t b;
    int     exp_stalls;
  } vec_t;

  // Model: each producer that left D is remembered with the absolute cycle its result is
  // available; a consumer at cycle c needing it at c+Tuse stalls while c+Tuse < ready.
  typedef struct {
    int rg;
    int ready;
  } rec_t;

  rec_t recs[$];
  int   cyc;
  int   md_lo, md_hi;
  bit   last_stall_m;
  bit   last_busy_dut;
  instr_t cur;

  int tests_run;
  int tests_failed;

  task automatic chk(input string nm, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic instr_t mk(input int rs, input int tuse_rs, input int rt, input int tuse_rt,
                                input int a3, input int tnew, input bit st, input bit dv,
                                input bit use_md);
    instr_t r;
    r.rs = 5'(rs);       r.tuse_rs = 2'(tuse_rs);
    r.rt = 5'(rt);       r.tuse_rt = 2'(tuse_rt);
    r.a3 = 5'(a3);       r.tnew    = 2'(tnew);
    r.md_start = st;     r.md_div  = dv;       r.md_use = use_md;
    return r;
  endfunction

  function automatic instr_t nop();
    return mk(0, TUSE_NONE, 0, TUSE_NONE, 0, TNEW_LINK, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic apply(input instr_t i);
    cur               = i;
    hz_if.RS_D        = i.rs;
    hz_if.TuseRS_D    = i.tuse_rs;
    hz_if.RT_D        = i.rt;
    hz_if.TuseRT_D    = i.tuse_rt;
    hz_if.A3_D        = i.a3;
    hz_if.TnewE_D     = i.tnew;
    hz_if.MDStart_D   = i.md_start;
    hz_if.MDIsDiv_D   = i.md_div;
    hz_if.MDUse_D     = i.md_use;
  endtask

  function automatic bit model_haz(input int src, input int tuse);
    if (src == 0) return 1'b0;
    foreach (recs[k]) if (recs[k].rg == src && cyc + tuse < recs[k].ready) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_busy();
    return (cyc >= md_lo) && (cyc <= md_hi);
  endfunction

  task automatic model_reset();
    recs.delete();
    cyc   = 0;
    md_lo = 1;
    md_hi = 0;
  endtask

  // One clock cycle with the currently applied D-stage instruction.
  task automatic cycle();
    bit st_m, bz_m;
    @(negedge CLK);
    bz_m = model_busy();
    st_m = model_haz(int'(cur.rs), int'(cur.tuse_rs)) ||
           model_haz(int'(cur.rt), int'(cur.tuse_rt)) || (cur.md_use && bz_m);
    chk("stall", int'(hz_if.Stall), int'(st_m));
    chk("flushe", int'(hz_if.FlushE), int'(st_m));
    chk("busy", int'(hz_if.Busy), int'(bz_m));
    last_stall_m  = st_m;
    last_busy_dut = hz_if.Busy;
    @(posedge CLK);
    if (!st_m) begin
      if (cur.a3 != 0) recs.push_back('{rg: int'(cur.a3), ready: cyc + 1 + int'(cur.tnew)});
      if (cur.md_start) begin
        md_lo = cyc + 1;
        md_hi = cyc + 1 + (cur.md_div ? DIV_N : MULT_N);
      end
    end
    while (recs.size() > 4) void'(recs.pop_front());
    cyc++;
    #1;
  endtask

  // Hold an instruction in D until the model lets it advance; returns stall cycles.
  task automatic issue(input instr_t i, output int stalls);
    apply(i);
    stalls = 0;
    for (int n = 0; n < 30; n++) begin
      cycle();
      if (!last_stall_m) return;
      stalls++;
    end
    chk("issue_timeout", stalls, -1);
  endtask

  task automatic do_reset();
    apply(nop());
    Reset = 1'b1;
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    model_reset();
  endtask

  vec_t vecs[11];
  int   s;
  int   bcnt;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    Reset        = 1'b1;
    apply(nop());
    model_reset();
    #12;
    chk("reset_stall", int'(hz_if.Stall), 0);
    chk("reset_busy", int'(hz_if.Busy), 0);
    @(posedge CLK);
    #1;
    Reset = 1'b0;

    vecs[0]  = '{mk(0,3,0,3,8,2,0,0,0), mk(8,1,0,3,0,0,0,0,0), 1};  // load-use
    vecs[1]  = '{mk(0,3,0,3,9,1,0,0,0), mk(9,0,0,3,0,0,0,0,0), 1};  // branch after ALU
    vecs[2]  = '{mk(0,3,0,3,9,2,0,0,0), mk(9,0,0,3,0,0,0,0,0), 2};  // branch after load
    vecs[3]  = '{mk(0,3,0,3,0,2,0,0,0), mk(0,0,0,0,0,0,0,0,0), 0};  // $0
    vecs[4]  = '{mk(0,3,0,3,8,2,0,0,0), mk(8,3,8,3,0,0,0,0,0), 0};  // no read
    vecs[5]  = '{mk(0,3,0,3,5,2,0,0,0), mk(0,3,5,1,0,0,0,0,0), 1};  // rt load-use
    vecs[6]  = '{mk(0,3,0,3,5,2,0,0,0), mk(0,3,5,2,0,0,0,0,0), 0};  // store data after load
    vecs[7]  = '{mk(0,3,0,3,0,0,1,1,1), mk(0,3,0,3,7,1,0,0,1), 11}; // div then mflo
    vecs[8]  = '{mk(0,3,0,3,0,0,1,0,1), mk(0,3,0,3,7,1,0,0,1), 6};  // mult then mflo
    vecs[9]  = '{mk(0,3,0,3,0,0,1,0,1), mk(1,1,2,1,3,1,0,0,0), 0};  // mult then add
    vecs[10] = '{mk(0,3,0,3,31,0,0,0,0), mk(31,0,0,3,0,0,0,0,0), 0}; // link then jr

    foreach (vecs[v]) begin
      do_reset();
      issue(vecs[v].a, s);
      issue(vecs[v].b, s);
      chk($sformatf("vec%0d_stalls", v), s, vecs[v].exp_stalls);
      apply(nop());
      repeat (3) cycle();
    end

    // Busy window length: mult and div issued once, then idle
    for (int d = 0; d < 2; d++) begin
      do_reset();
      issue(mk(0,3,0,3,0,0,1,d[0],1), s);
      apply(nop());
      bcnt = 0;
      repeat (14) begin
        cycle();
        if (last_busy_dut) bcnt++;
      end
      chk(d == 0 ? "mult_busy_len" : "div_busy_len", bcnt, d == 0 ? MULT_N + 1 : DIV_N + 1);
    end

    // Async reset while the div counter sits at 7
    do_reset();
    issue(mk(0,3,0,3,0,0,1,1,1), s);
    apply(mk(0,3,0,3,7,1,0,0,1));
    repeat (4) cycle();
    chk("pre_rst_cnt", int'(dut.u_md_cnt.cnt_q), 7);
    chk("pre_rst_busy", int'(hz_if.Busy), 1);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_rst_busy", int'(hz_if.Busy), 0);
    chk("async_rst_stall", int'(hz_if.Stall), 0);
    chk("async_rst_cnt", int'(dut.u_md_cnt.cnt_q), 0);
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    model_reset();
    repeat (2) cycle();

    // Random traffic on a small register window so hazards are frequent
    do_reset();
    apply(nop());
    for (int n = 0; n < 400; n++) begin
      if (!last_stall_m) begin
        instr_t r;
        r.rs       = 5'($urandom_range(0, 3));
        r.tuse_rs  = 2'($urandom_range(0, 3));
        r.rt       = 5'($urandom_range(0, 3));
        r.tuse_rt  = 2'($urandom_range(0, 3));
        r.a3       = 5'($urandom_range(0, 3));
        r.tnew     = 2'($urandom_range(0, 2));
        r.md_start = ($urandom_range(0, 15) == 0);
        r.md_div   = 1'($urandom_range(0, 1));
        r.md_use   = r.md_start || ($urandom_range(0, 7) == 0);
        apply(r);
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
